pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised pipeline-stage register for the MIPS pipeline. It is the successor to the fixed D→E latch. It carries a PC plus a configurable-width payload bundle (Imm32, Instr, RD1, RD2, …) between stages using a valid/ready handshake. A one-entry skid slot lets `in_ready` be registered, so a downstream stall never combinationally reaches the upstream stage. It adds synchronous flush (bubble insertion) and a saturating stall counter, and is instantiated once per stage boundary (F/D, D/E, E/M, M/W).

## Interface
Parameters:
- `PC_W`, 32, PC field width
- `DATA_W`, 128, payload width (concatenated stage fields)
- `RESET_PC`, 32'h0000_3000, reset/flush value of the PC field
- `CNT_W`, 16, stall counter width

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  upstream has a beat
- `in_ready`  out  1  stage can accept; registered
- `in_pc`  in  PC_W  upstream PC
- `in_data`  in  DATA_W  upstream payload
- `flush`  in  1  synchronous kill of all held beats
- `out_valid`  out  1  output beat present
- `out_ready`  in  1  downstream accepts
- `out_pc`  out  PC_W  PC of output beat
- `out_data`  out  DATA_W  payload of output beat; reads 0 while `out_valid`=0
- `stall_cnt`  out  CNT_W  saturating count of stalled cycles

## Operation
- Storage: main slot (`main_pc`, `main_data`) drives the outputs; skid slot (`skid_pc`, `skid_data`) holds one overflow beat.
- States:
  - EMPTY: `out_valid`=0, `in_ready`=1
  - ONE: `out_valid`=1, `in_ready`=1
  - TWO: `out_valid`=1, `in_ready`=0
- Accept = `in_valid && in_ready`. Deliver = `out_valid && out_ready`.
- Transitions when `flush`=0:
  - EMPTY: accept → ONE, main←in.
  - ONE, deliver and accept → ONE, main←in.
  - ONE, deliver only → EMPTY.
  - ONE, accept only → TWO, skid←in.
  - ONE, neither → ONE, hold.
  - TWO, deliver → ONE, main←skid; no accept is possible.
  - TWO, no deliver → hold.
- `flush`=1 has top priority:
  - Next state is EMPTY.
  - `main_pc` and `skid_pc` ← RESET_PC; `main_data` and `skid_data` ← 0.
  - A beat accepted in the same cycle is discarded.
  - A beat delivered in the same cycle counts as delivered; downstream handles its own flush.
- Beat order is strictly FIFO; no beat is ever duplicated or dropped, except by flush.
- `stall_cnt`:
  - Increments each cycle with `out_valid && !out_ready`.
  - Saturates at 2^CNT_W−1.
  - Not cleared by flush; cleared only by reset.
- Reset (`reset`=0, asynchronous):
  - State EMPTY; all PC fields RESET_PC; all data fields 0; `stall_cnt` 0.
  - Therefore `out_valid`=0, `in_ready`=1, `out_pc`=RESET_PC, `out_data`=0.
  - Reset asserted mid-transfer drops all held beats immediately.

## Timing
- Latency: 1 cycle; a beat accepted at edge N is visible at `out_*` after edge N.
- Throughput: 1 beat/cycle while `out_ready`=1.
- `in_ready` is a pure function of state (flop-derived), with no combinational path from `out_ready` or `in_valid`.
- `out_valid`, `out_pc`, `out_data` depend only on state and main slot, not on any input in the same cycle.
- After a downstream stall: `in_ready` falls on the edge entering TWO and rises one edge after the stall releases.
- Reset deassertion is synchronised externally; the first active edge after release can accept.

## Structure
- Shared package `pipe_pkg`:
  - state encoding constants `PS_EMPTY`=2'd0, `PS_ONE`=2'd1, `PS_TWO`=2'd2
  - default `RESET_PC`
  - stage payload width constants (e.g. `DE_DATA_W`=128)
- One natural sub-module, `pipe_slot`: a PC+data register with load enable and synchronous clear-to-bubble. It is instantiated twice (main and skid).
- Control FSM and `stall_cnt` live in the top module.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with random inputs → `out_valid`=0, `in_ready`=1, `out_pc`=32'h3000, `out_data`=0, `stall_cnt`=0.
- Streaming: `out_ready`=1; PCs 0x3000, 0x3004, 0x3008 on consecutive cycles → same PCs appear one cycle later, back-to-back, `stall_cnt`=0.
- Skid stall:
  - Send 0x3000 then 0x3004 while `out_ready`=0 → `in_ready`=0 after the second accept, and `out_pc` holds 0x3000.
  - Then raise `out_ready` → 0x3004 follows next cycle; `in_ready`=1 again; `stall_cnt` equals the stall cycles.
- Flush in TWO: flush with `in_valid`=1, PC 0x300C → next cycle `out_valid`=0, `out_pc`=32'h3000, `out_data`=0, and 0x300C never appears.
- Counter saturation: `CNT_W`=3, stall 10 cycles → `stall_cnt`=7 and stays there.
- Async reset mid-TWO: pulse `reset` low between edges → outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline-stage buffers: handshake state
// encoding, the default reset PC and the per-boundary payload widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } pipe_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    // Payload widths of the concatenated stage fields at each boundary.
    localparam int FD_DATA_W = 64;
    localparam int DE_DATA_W = 128;
    localparam int EM_DATA_W = 96;
    localparam int MW_DATA_W = 96;

    function automatic logic state_is_full(input pipe_state_t s);
        return s == PS_TWO;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One PC+payload register of a pipeline-stage buffer, with load enable and a
// synchronous clear that turns the slot into a bubble.
module pipe_slot #(
    parameter int              PC_W     = 32,
    parameter int              DATA_W   = 128,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(pipe_pkg::DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [PC_W-1:0]   load_pc,
    input  logic [DATA_W-1:0] load_data,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] data
);

    // Clear wins over load so a flush always leaves a clean bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc   <= RESET_PC;
            data <= '0;
        end else if (clear) begin
            pc   <= RESET_PC;
            data <= '0;
        end else if (load) begin
            pc   <= load_pc;
            data <= load_data;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline-stage register with a one-entry skid slot, so in_ready
// comes straight from a flop; also provides flush and a saturating stall count.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter int              DATA_W   = 128,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(pipe_pkg::DEFAULT_RESET_PC),
    parameter int              CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_t       state;
    pipe_state_t       next_state;
    logic              in_ready_q;
    logic              accept;
    logic              deliver;
    logic              main_load;
    logic              main_clear;
    logic              main_from_skid;
    logic              skid_load;
    logic              skid_clear;
    logic [PC_W-1:0]   main_pc;
    logic [DATA_W-1:0] main_data;
    logic [PC_W-1:0]   skid_pc;
    logic [DATA_W-1:0] skid_data;
    logic [PC_W-1:0]   main_next_pc;
    logic [DATA_W-1:0] main_next_data;

    assign in_ready  = in_ready_q;
    assign out_valid = (state != PS_EMPTY);
    assign out_pc    = main_pc;
    assign out_data  = out_valid ? main_data : '0;
    assign accept    = in_valid && in_ready_q;
    assign deliver   = out_valid && out_ready;

    assign main_next_pc   = main_from_skid ? skid_pc   : in_pc;
    assign main_next_data = main_from_skid ? skid_data : in_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= PS_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= next_state;
            in_ready_q <= !state_is_full(next_state);
        end
    end

    // A slot that stops holding a live beat is cleared, so an idle stage
    // always presents a bubble rather than a stale beat.
    always_comb begin
        next_state     = state;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            next_state = PS_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state)
                PS_EMPTY: begin
                    if (accept) begin
                        next_state = PS_ONE;
                        main_load  = 1'b1;
                    end
                end
                PS_ONE: begin
                    if (deliver && accept) begin
                        main_load = 1'b1;
                    end else if (deliver) begin
                        next_state = PS_EMPTY;
                        main_clear = 1'b1;
                    end else if (accept) begin
                        next_state = PS_TWO;
                        skid_load  = 1'b1;
                    end
                end
                PS_TWO: begin
                    if (deliver) begin
                        next_state     = PS_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: begin
                    next_state = PS_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    // Counts stalled cycles across flushes; only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    pipe_slot #(
        .PC_W     (PC_W),
        .DATA_W   (DATA_W),
        .RESET_PC (RESET_PC)
    ) u_main_slot (
        .clk       (clk),
        .reset     (reset),
        .load      (main_load),
        .clear     (main_clear),
        .load_pc   (main_next_pc),
        .load_data (main_next_data),
        .pc        (main_pc),
        .data      (main_data)
    );

    pipe_slot #(
        .PC_W     (PC_W),
        .DATA_W   (DATA_W),
        .RESET_PC (RESET_PC)
    ) u_skid_slot (
        .clk       (clk),
        .reset     (reset),
        .load      (skid_load),
        .clear     (skid_clear),
        .load_pc   (in_pc),
        .load_data (in_data),
        .pc        (skid_pc),
        .data      (skid_data)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a depth-2 FIFO model checked every cycle, plus
// directed vectors with hand-computed expectations; a CNT_W=3 copy tracks saturation.
module tb_pipe_stage_buf;

    localparam int PC_W   = 32;
    localparam int DATA_W = 128;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic [PC_W-1:0]   in_pc = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              flush = 1'b0;
    logic              out_ready = 1'b0;
    logic              in_ready;
    logic              out_valid;
    logic [PC_W-1:0]   out_pc;
    logic [DATA_W-1:0] out_data;
    logic [15:0]       stall_cnt;
    logic              sat_in_ready;
    logic              sat_out_valid;
    logic [PC_W-1:0]   sat_out_pc;
    logic [DATA_W-1:0] sat_out_data;
    logic [2:0]        sat_stall_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] data;
    } beat_t;

    beat_t model_q[$];
    int    model_stall = 0;

    pipe_stage_buf #(
        .PC_W     (PC_W),
        .DATA_W   (DATA_W),
        .RESET_PC (32'h0000_3000),
        .CNT_W    (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    pipe_stage_buf #(
        .PC_W     (PC_W),
        .DATA_W   (DATA_W),
        .RESET_PC (32'h0000_3000),
        .CNT_W    (3)
    ) dut_sat (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (sat_in_ready),
        .in_pc     (in_pc),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (sat_out_valid),
        .out_ready (out_ready),
        .out_pc    (sat_out_pc),
        .out_data  (sat_out_data),
        .stall_cnt (sat_stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] payload_of(input logic [PC_W-1:0] pc);
        return {pc, ~pc, pc ^ 32'hA5A5_5A5A, pc + 32'h1111_1111};
    endfunction

    function automatic int sat_min(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic check_output(input string name, input logic [DATA_W-1:0] actual,
                                input logic [DATA_W-1:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [PC_W-1:0] pc,
                                  input logic rdy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_data   = payload_of(pc);
        out_ready = rdy;
        flush     = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stage behaves as a two-deep FIFO whose ready is "not full" at cycle start.
    always @(posedge clk or negedge reset) begin : model
        bit    acc;
        bit    del;
        beat_t b;
        if (!reset) begin
            model_q.delete();
            model_stall = 0;
        end else begin
            acc = in_valid && (model_q.size() < 2);
            del = (model_q.size() > 0) && out_ready;
            if ((model_q.size() > 0) && !out_ready) model_stall++;
            if (del) void'(model_q.pop_front());
            if (flush) begin
                model_q.delete();
            end else if (acc) begin
                b.pc   = in_pc;
                b.data = in_data;
                model_q.push_back(b);
            end
        end
    end

    always @(negedge clk) begin : compare
        logic exp_valid;
        exp_valid = model_q.size() > 0;
        check_output("cyc_out_valid", out_valid, exp_valid);
        check_output("cyc_in_ready", in_ready, model_q.size() < 2);
        check_output("cyc_sat_out_valid", sat_out_valid, exp_valid);
        if (exp_valid) begin
            check_output("cyc_out_pc", out_pc, model_q[0].pc);
            check_output("cyc_out_data", out_data, model_q[0].data);
        end else begin
            check_output("cyc_out_data_bubble", out_data, '0);
        end
        check_output("cyc_stall_cnt", stall_cnt, sat_min(model_stall, 65535));
        check_output("cyc_sat_stall_cnt", sat_stall_cnt, sat_min(model_stall, 7));
    end

    initial begin
        reset = 1'b0;
        repeat (3) begin
            in_valid  = 1'($urandom);
            in_pc     = $urandom;
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            flush     = 1'($urandom);
            out_ready = 1'($urandom);
            step();
        end
        check_output("rst_out_valid", out_valid, 1'b0);
        check_output("rst_in_ready", in_ready, 1'b1);
        check_output("rst_out_pc", out_pc, 32'h3000);
        check_output("rst_out_data", out_data, '0);
        check_output("rst_stall_cnt", stall_cnt, 16'd0);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        reset = 1'b1;

        apply_stimulus(1'b1, 32'h3000, 1'b1, 1'b0);
        step();
        check_output("stream_pc0", out_pc, 32'h3000);
        check_output("stream_valid0", out_valid, 1'b1);
        check_output("stream_data0", out_data, payload_of(32'h3000));
        apply_stimulus(1'b1, 32'h3004, 1'b1, 1'b0);
        step();
        check_output("stream_pc1", out_pc, 32'h3004);
        apply_stimulus(1'b1, 32'h3008, 1'b1, 1'b0);
        step();
        check_output("stream_pc2", out_pc, 32'h3008);
        check_output("stream_ready2", in_ready, 1'b1);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        check_output("stream_drained", out_valid, 1'b0);
        check_output("stream_stall", stall_cnt, 16'd0);

        apply_stimulus(1'b1, 32'h3000, 1'b0, 1'b0);
        step();
        check_output("skid_ready_one", in_ready, 1'b1);
        apply_stimulus(1'b1, 32'h3004, 1'b0, 1'b0);
        step();
        check_output("skid_ready_two", in_ready, 1'b0);
        check_output("skid_hold_pc", out_pc, 32'h3000);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        check_output("skid_still_full", in_ready, 1'b0);
        check_output("skid_still_pc", out_pc, 32'h3000);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        check_output("skid_next_pc", out_pc, 32'h3004);
        check_output("skid_next_data", out_data, payload_of(32'h3004));
        check_output("skid_ready_back", in_ready, 1'b1);
        check_output("skid_stall", stall_cnt, 16'd2);
        step();
        check_output("skid_drained", out_valid, 1'b0);

        apply_stimulus(1'b1, 32'h3010, 1'b0, 1'b0);
        step();
        apply_stimulus(1'b1, 32'h3014, 1'b0, 1'b0);
        step();
        check_output("flush_pre_full", in_ready, 1'b0);
        apply_stimulus(1'b1, 32'h300C, 1'b0, 1'b1);
        step();
        check_output("flush_valid", out_valid, 1'b0);
        check_output("flush_pc", out_pc, 32'h3000);
        check_output("flush_data", out_data, '0);
        check_output("flush_ready", in_ready, 1'b1);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (3) step();
        check_output("flush_no_ghost", out_valid, 1'b0);
        check_output("flush_stall_kept", stall_cnt, 16'd4);

        apply_stimulus(1'b1, 32'h3020, 1'b0, 1'b0);
        step();
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (10) step();
        check_output("sat_cnt7", sat_stall_cnt, 3'd7);
        check_output("sat_wide_cnt", stall_cnt, 16'd14);
        repeat (2) step();
        check_output("sat_cnt_stays", sat_stall_cnt, 3'd7);
        check_output("sat_wide_cnt2", stall_cnt, 16'd16);

        apply_stimulus(1'b1, 32'h3024, 1'b0, 1'b0);
        step();
        check_output("arst_pre_full", in_ready, 1'b0);
        check_output("arst_pre_pc", out_pc, 32'h3020);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        check_output("arst_valid", out_valid, 1'b0);
        check_output("arst_ready", in_ready, 1'b1);
        check_output("arst_pc", out_pc, 32'h3000);
        check_output("arst_data", out_data, '0);
        check_output("arst_stall", stall_cnt, 16'd0);
        check_output("arst_sat_stall", sat_stall_cnt, 3'd0);
        #1;
        reset = 1'b1;

        apply_stimulus(1'b1, 32'h3030, 1'b1, 1'b0);
        step();
        check_output("post_rst_accept", out_pc, 32'h3030);

        for (int i = 0; i < 48; i++) begin
            apply_stimulus((i % 3) != 0, 32'h4000 + 32'(4 * i),
                           ((i % 4) != 1) && ((i % 7) != 3), i == 20);
            step();
        end
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (3) step();
        check_output("final_drained", out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
